blowfish128_decrypt: RTL and testbench

Blowfish-128 decryption core: iterative 16-round Feistel engine on 128-bit blocks (two 64-bit halves). Applies the 18-entry P-array in reverse order and drives the shared F-function block as its initiator. Sits opposite the encryption datapath; a block encrypted with the same P-array must round-trip to its plaintext. Valid/ready streaming on input and output; P-array loaded through a simple write port.

---
 rtl/blowfish128_pkg.sv | 20 ++
 rtl/blowfish128_ffunc.sv | 42 ++++
 rtl/blowfish128_decrypt.sv | 120 ++++++++++++
 tb/tb_blowfish128_decrypt.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blowfish128_pkg.sv
// Shared constants, FSM encoding and F-function mixing constant for the Blowfish-128 decrypt core.
package blowfish128_pkg;

    localparam int NUM_ROUNDS_DEF = 16;
    localparam int P_ENTRIES      = NUM_ROUNDS_DEF + 2;
    localparam int BLOCK_W        = 128;
    localparam int HALF_W         = 64;

    localparam logic [HALF_W-1:0] F_MIX = 64'h9E37_79B9_7F4A_7C15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_FWAIT = 3'd2,
        ST_POST  = 3'd3,
        ST_FINAL = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/blowfish128_ffunc.sv
// Multi-cycle F-function: Y = rotl(X,13) ^ (X + F_MIX); outputValid rises on the third enabled edge.
module blowfish128_ffunc
    import blowfish128_pkg::*;
(
    input  logic              Clk,
    input  logic              RstN,
    input  logic              Enable,
    input  logic [HALF_W-1:0] X,
    output logic [HALF_W-1:0] Y,
    output logic              outputValid
);

    logic [1:0]        cnt;
    logic [HALF_W-1:0] rot_q;
    logic [HALF_W-1:0] sum_q;

    // Dropping Enable is the only way to restart the pipeline for a new X.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            cnt         <= '0;
            rot_q       <= '0;
            sum_q       <= '0;
            Y           <= '0;
            outputValid <= 1'b0;
        end else if (!Enable) begin
            cnt         <= '0;
            rot_q       <= '0;
            sum_q       <= '0;
            Y           <= '0;
            outputValid <= 1'b0;
        end else begin
            if (cnt != 2'd3) cnt <= cnt + 2'd1;
            if (cnt == 2'd0) begin
                rot_q <= {X[50:0], X[63:51]};
                sum_q <= X + F_MIX;
            end
            if (cnt == 2'd1) Y <= rot_q ^ sum_q;
            if (cnt == 2'd2) outputValid <= 1'b1;
        end
    end

endmodule

// File: rtl/blowfish128_decrypt.sv
// Iterative Blowfish-128 decryption core: walks the P-array from the top entry down,
// one Feistel round per six cycles, using the shared F-function block.
//
// state | meaning
// IDLE  | ready for a ciphertext block, key writes allowed
// PRE   | L ^= P[k]
// FWAIT | F enabled on L, waiting for outputValid
// POST  | fold Y into R and swap (no swap when k==2)
// FINAL | whitening with P[1]/P[0], register the plaintext
// DONE  | plaintext presented until out_ready, key writes allowed
module blowfish128_decrypt
    import blowfish128_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int KEY_AW     = 5
) (
    input  logic               Clk,
    input  logic               RstN,
    input  logic               key_we,
    input  logic [KEY_AW-1:0]  key_addr,
    input  logic [HALF_W-1:0]  key_wdata,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);

    localparam int P_N = NUM_ROUNDS + 2;
    localparam logic [KEY_AW-1:0] K_TOP  = KEY_AW'(NUM_ROUNDS + 1);
    localparam logic [KEY_AW-1:0] K_LAST = KEY_AW'(2);

    state_t                      state;
    logic [KEY_AW-1:0]           k;
    logic [HALF_W-1:0]           l_q;
    logic [HALF_W-1:0]           r_q;
    logic [P_N-1:0][HALF_W-1:0]  p_array;
    logic                        f_en;
    logic [HALF_W-1:0]           f_y;
    logic                        f_valid;
    logic                        key_ok;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign f_en      = (state == ST_FWAIT);

    // Writes are locked out mid-block so every round of a block sees one key.
    assign key_ok = key_we && (state == ST_IDLE || state == ST_DONE)
                    && (int'(key_addr) < P_N);

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            p_array <= '0;
        end else if (key_ok) begin
            p_array[key_addr] <= key_wdata;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state    <= ST_IDLE;
            k        <= '0;
            l_q      <= '0;
            r_q      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        l_q   <= in_data[BLOCK_W-1:HALF_W];
                        r_q   <= in_data[HALF_W-1:0];
                        k     <= K_TOP;
                        state <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    l_q   <= l_q ^ p_array[k];
                    state <= ST_FWAIT;
                end
                ST_FWAIT: begin
                    if (f_valid) state <= ST_POST;
                end
                ST_POST: begin
                    if (k > K_LAST) begin
                        r_q   <= l_q;
                        l_q   <= r_q ^ f_y;
                        k     <= k - KEY_AW'(1);
                        state <= ST_PRE;
                    end else begin
                        r_q   <= r_q ^ f_y;
                        state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    l_q      <= l_q ^ p_array[0];
                    r_q      <= r_q ^ p_array[1];
                    out_data <= {l_q ^ p_array[0], r_q ^ p_array[1]};
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    blowfish128_ffunc u_ffunc (
        .Clk         (Clk),
        .RstN        (RstN),
        .Enable      (f_en),
        .X           (l_q),
        .Y           (f_y),
        .outputValid (f_valid)
    );

endmodule

// File: tb/tb_blowfish128_decrypt.sv
// Directed bench for blowfish128_decrypt: round-trip, latency, handshakes, key locking and reset.
module tb_blowfish128_decrypt;

    logic         Clk = 1'b0;
    logic         RstN;
    logic         key_we;
    logic [4:0]   key_addr;
    logic [63:0]  key_wdata;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] pk [18];

    always #5 Clk = ~Clk;

    blowfish128_decrypt dut (
        .Clk       (Clk),
        .RstN      (RstN),
        .key_we    (key_we),
        .key_addr  (key_addr),
        .key_wdata (key_wdata),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [63:0] f_model(input logic [63:0] x);
        logic [63:0] rot;
        rot = (x << 13) | (x >> 51);
        return rot ^ (x + 64'h9E3779B97F4A7C15);
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [63:0] l, r, t;
        l = pt[127:64];
        r = pt[63:0];
        for (int i = 0; i < 16; i++) begin
            l = l ^ pk[i];
            r = r ^ f_model(l);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        r = r ^ pk[16];
        l = l ^ pk[17];
        return {l, r};
    endfunction

    function automatic logic [127:0] decrypt(input logic [127:0] ct);
        logic [63:0] l, r, t;
        l = ct[127:64];
        r = ct[63:0];
        for (int i = 17; i >= 2; i--) begin
            l = l ^ pk[i];
            r = r ^ f_model(l);
            if (i != 2) begin
                t = l; l = r; r = t;
            end
        end
        r = r ^ pk[1];
        l = l ^ pk[0];
        return {l, r};
    endfunction

    task automatic set_rt_key();
        for (int i = 0; i < 18; i++) pk[i] = 64'h0101010101010101 * 64'(i);
    endtask

    task automatic load_key();
        for (int i = 0; i < 18; i++) begin
            key_we    = 1'b1;
            key_addr  = 5'(i);
            key_wdata = pk[i];
            @(posedge Clk); #1;
        end
        key_we = 1'b0;
    endtask

    task automatic write_key(input logic [4:0] addr, input logic [63:0] data);
        key_we    = 1'b1;
        key_addr  = addr;
        key_wdata = data;
        @(posedge Clk); #1;
        key_we = 1'b0;
    endtask

    // wr_cycle: -1 none, 0 together with the accepting cycle, >0 that many cycles after acceptance
    task automatic run_block(input logic [127:0] ct, input int wr_cycle,
                             input logic [4:0] wr_addr, input logic [63:0] wr_data,
                             output logic [127:0] pt, output int lat, output int wait_cyc,
                             output int pulses, output bit gap_bad, output bit ready_bad);
        bit prev_en;
        int low_run;
        in_data  = ct;
        in_valid = 1'b1;
        wait_cyc = 0;
        lat      = 0;
        pulses   = 0;
        gap_bad  = 1'b0;
        ready_bad = 1'b0;
        pt       = '0;
        while (in_ready !== 1'b1 && wait_cyc < 300) begin
            @(posedge Clk); #1;
            wait_cyc++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, wait_cyc);
            in_valid = 1'b0;
            return;
        end
        if (wr_cycle == 0) begin
            key_we = 1'b1; key_addr = wr_addr; key_wdata = wr_data;
        end
        @(posedge Clk); #1;
        in_valid = 1'b0;
        key_we   = 1'b0;
        prev_en  = 1'b0;
        low_run  = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (dut.f_en === 1'b1) begin
                if (!prev_en) begin
                    pulses++;
                    if (low_run < 2) gap_bad = 1'b1;
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_en = dut.f_en;
            if (in_ready !== 1'b0) ready_bad = 1'b1;
            if (wr_cycle > 0 && lat == wr_cycle) begin
                key_we = 1'b1; key_addr = wr_addr; key_wdata = wr_data;
            end
            @(posedge Clk); #1;
            key_we = 1'b0;
            lat++;
        end
        if (out_valid !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
        end
        pt = out_data;
    endtask

    task automatic test_reset();
        RstN = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data: got %h need 0", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_checks++; if (dut.f_en !== 1'b0) begin n_fail++; $display("FAIL reset_f_en: got %b need 0", dut.f_en); end
        n_checks++; if (dut.p_array !== '0) begin n_fail++; $display("FAIL reset_p_array: got nonzero need 0"); end
        #2 RstN = 1'b1;
        @(posedge Clk); #1;
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: in_ready=%b busy=%b need 1/0", in_ready, busy); end
    endtask

    task automatic test_zero();
        logic [127:0] pt, exp_pt;
        int lat, wc, pulses;
        bit gap_bad, ready_bad;
        for (int i = 0; i < 18; i++) pk[i] = '0;
        exp_pt = decrypt(128'h0);
        run_block(128'h0, -1, 5'd0, 64'h0, pt, lat, wc, pulses, gap_bad, ready_bad);
        n_checks++; if (pt !== exp_pt) begin n_fail++; $display("FAIL zero_data: got %h need %h", pt, exp_pt); end
        n_checks++; if (pulses != 16) begin n_fail++; $display("FAIL zero_f_pulses: got %0d need 16", pulses); end
        n_checks++; if (gap_bad) begin n_fail++; $display("FAIL zero_f_gap: got gap<2 need >=2 low cycles"); end
        n_checks++; if (ready_bad) begin n_fail++; $display("FAIL zero_in_ready: got 1 during block need 0"); end
    endtask

    task automatic test_round_trip();
        logic [127:0] pt, ct;
        int lat, wc, pulses;
        bit gap_bad, ready_bad;
        set_rt_key();
        load_key();
        ct = encrypt(128'h0123456789ABCDEF_FEDCBA9876543210);
        run_block(ct, -1, 5'd0, 64'h0, pt, lat, wc, pulses, gap_bad, ready_bad);
        n_checks++; if (pt !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin n_fail++; $display("FAIL rt_data: got %h need 0123456789abcdeffedcba9876543210", pt); end
        n_checks++; if (lat != 97) begin n_fail++; $display("FAIL rt_latency: got %0d need 97", lat); end
        @(posedge Clk); #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rt_return_idle: in_ready=%b out_valid=%b need 1/0", in_ready, out_valid); end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, hold, exp_pt;
        int lat, wc, pulses, bad;
        bit gap_bad, ready_bad;
        exp_pt = decrypt(128'hCAFEBABE_DEADBEEF_00000000_FFFFFFFF);
        out_ready = 1'b0;
        run_block(128'hCAFEBABE_DEADBEEF_00000000_FFFFFFFF, -1, 5'd0, 64'h0, pt, lat, wc, pulses, gap_bad, ready_bad);
        hold = out_data;
        n_checks++; if (hold !== exp_pt) begin n_fail++; $display("FAIL bp_data: got %h need %h", hold, exp_pt); end
        in_data  = 128'h1111;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (out_valid !== 1'b1 || out_data !== hold || in_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_stall: got %0d unstable cycles need 0", bad); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk); #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b need 1/0/0", in_ready, out_valid, busy); end
        n_checks++; if (out_data !== hold) begin n_fail++; $display("FAIL bp_hold_after: got %h need %h", out_data, hold); end
    endtask

    task automatic test_key_lock();
        logic [127:0] pt, exp_pt, ct;
        int lat, wc, pulses, bad;
        bit gap_bad, ready_bad;
        ct = 128'h00112233445566778899AABBCCDDEEFF;
        exp_pt = decrypt(ct);
        run_block(ct, 30, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, pt, lat, wc, pulses, gap_bad, ready_bad);
        n_checks++; if (pt !== exp_pt) begin n_fail++; $display("FAIL midblock_write_data: got %h need %h", pt, exp_pt); end
        @(posedge Clk); #1;
        write_key(5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        pk[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        write_key(5'd20, 64'h1234);
        bad = 0;
        for (int i = 0; i < 18; i++) if (dut.p_array[i] !== pk[i]) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL key_table: got %0d wrong entries need 0", bad); end
        exp_pt = decrypt(ct);
        run_block(ct, -1, 5'd0, 64'h0, pt, lat, wc, pulses, gap_bad, ready_bad);
        n_checks++; if (pt !== exp_pt) begin n_fail++; $display("FAIL idle_write_data: got %h need %h", pt, exp_pt); end
        pk[17] = 64'h5A5A_5A5A_0F0F_0F0F;
        exp_pt = decrypt(ct);
        run_block(ct, 0, 5'd17, 64'h5A5A_5A5A_0F0F_0F0F, pt, lat, wc, pulses, gap_bad, ready_bad);
        n_checks++; if (pt !== exp_pt) begin n_fail++; $display("FAIL same_cycle_write_data: got %h need %h", pt, exp_pt); end
    endtask

    task automatic test_reset_midop();
        logic [127:0] pt, ct;
        int lat, wc, pulses, cyc;
        bit gap_bad, ready_bad;
        cyc = 0;
        in_data  = 128'hABCD;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && cyc < 300) begin @(posedge Clk); #1; cyc++; end
        @(posedge Clk); #1;
        in_valid = 1'b0;
        repeat (40) @(posedge Clk);
        #1;
        n_checks++; if (dut.f_en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL midop_pre_reset: f_en=%b busy=%b need 1/1", dut.f_en, busy); end
        #2 RstN = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || dut.f_en !== 1'b0) begin n_fail++; $display("FAIL midop_reset_outputs: out_valid=%b busy=%b f_en=%b need 0/0/0", out_valid, busy, dut.f_en); end
        n_checks++; if (dut.p_array !== '0) begin n_fail++; $display("FAIL midop_reset_p_array: got nonzero need 0"); end
        repeat (2) @(posedge Clk);
        #3 RstN = 1'b1;
        @(posedge Clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midop_release_ready: got %b need 1", in_ready); end
        set_rt_key();
        load_key();
        ct = encrypt(128'h0123456789ABCDEF_FEDCBA9876543210);
        run_block(ct, -1, 5'd0, 64'h0, pt, lat, wc, pulses, gap_bad, ready_bad);
        n_checks++; if (pt !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin n_fail++; $display("FAIL midop_recover_data: got %h need 0123456789abcdeffedcba9876543210", pt); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt1, pt2, exp1, exp2, ct1, ct2;
        int lat1, lat2, wc1, wc2, pulses;
        bit gap_bad, ready_bad;
        ct1  = 128'hFFEEDDCCBBAA99887766554433221100;
        ct2  = 128'h13579BDF02468ACE_FDB97531ECA86420;
        exp1 = decrypt(ct1);
        exp2 = decrypt(ct2);
        out_ready = 1'b1;
        run_block(ct1, -1, 5'd0, 64'h0, pt1, lat1, wc1, pulses, gap_bad, ready_bad);
        run_block(ct2, -1, 5'd0, 64'h0, pt2, lat2, wc2, pulses, gap_bad, ready_bad);
        n_checks++; if (pt1 !== exp1) begin n_fail++; $display("FAIL b2b_first: got %h need %h", pt1, exp1); end
        n_checks++; if (pt2 !== exp2) begin n_fail++; $display("FAIL b2b_second: got %h need %h", pt2, exp2); end
        n_checks++; if (lat1 != 97 || lat2 != 97) begin n_fail++; $display("FAIL b2b_latency: got %0d/%0d need 97/97", lat1, lat2); end
        n_checks++; if (wc2 != 1) begin n_fail++; $display("FAIL b2b_ready_gap: got %0d cycles need 1", wc2); end
        @(posedge Clk); #1;
    endtask

    initial begin
        RstN      = 1'b0;
        key_we    = 1'b0;
        key_addr  = '0;
        key_wdata = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        test_reset();
        test_zero();
        test_round_trip();
        test_backpressure();
        test_key_lock();
        test_reset_midop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
